// File: rtl/jpeg_byte_stuffer_if.sv
// Byte-stuffer stream interface.
// Groups the encoder word input and the stuffed byte output handshake.
//   enc_word_i   : packed entropy-coded word, first byte in the MSBs
//   enc_valid_i  : enc_word_i valid this cycle (no back-pressure)
//   frame_end_i  : one-cycle pulse, last word of the frame presented
//   byte_o       : stuffed scan byte
//   byte_valid_o : byte_o valid
//   byte_ready_i : sink accepts byte_o
// Modports: slave = stuffer side, master = encoder/sink side.
interface jpeg_byte_stuffer_if #(
    parameter int IN_WIDTH = 32
);
    logic [IN_WIDTH-1:0] enc_word_i;
    logic                enc_valid_i;
    logic                frame_end_i;
    logic [7:0]          byte_o;
    logic                byte_valid_o;
    logic                byte_ready_i;

    modport slave (
        input  enc_word_i,
        input  enc_valid_i,
        input  frame_end_i,
        input  byte_ready_i,
        output byte_o,
        output byte_valid_o
    );

    modport master (
        output enc_word_i,
        output enc_valid_i,
        output frame_end_i,
        output byte_ready_i,
        input  byte_o,
        input  byte_valid_o
    );
endinterface

// File: rtl/jpeg_byte_stuffer.sv
// JPEG scan byte stuffer.
// Buffers 32-bit entropy-coded words in a small FIFO, serializes them MSB byte
// first, inserts 0x00 after every 0xFF data byte and appends an EOI marker
// (FF D9, unstuffed) after a frame end.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   bus        : stream interface (slave modport), see jpeg_byte_stuffer_if
//   busy_o     : FIFO non-empty, word in flight or EOI pending/in flight
//   overflow_o : sticky, an input word was dropped on a full FIFO
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | nothing to send; waits for a word or EOI
// BYTE     | presenting current data byte of the word
// STUFF    | presenting 0x00 after an 0xFF data byte
// EOI_FF   | presenting first EOI marker byte 0xFF
// EOI_D9   | presenting second EOI marker byte 0xD9
//
// IN_WIDTH must be 32; FIFO_DEPTH must be a power of 2, at least 2.
module jpeg_byte_stuffer #(
    parameter int IN_WIDTH   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    jpeg_byte_stuffer_if.slave    bus,
    output logic                  busy_o,
    output logic                  overflow_o
);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYTE,
        S_STUFF,
        S_EOI_FF,
        S_EOI_D9
    } state_t;

    logic [IN_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                empty, full, push, pop;
    logic                nonempty_q;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]          idx_q, idx_d;
    logic                eoi_pending_q, eoi_clr, advance, xfer;
    logic [7:0]          cur_byte;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    // A pop on a full FIFO frees a slot at the same edge.
    assign push     = bus.enc_valid_i && (!full || pop);
    assign xfer     = bus.byte_valid_o && bus.byte_ready_i;
    assign cur_byte = shift_q[IN_WIDTH-1 -: 8];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= bus.enc_word_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            nonempty_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.enc_valid_i && !push) overflow_o <= 1'b1;
            nonempty_q <= !empty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            idx_q         <= '0;
            eoi_pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            if (eoi_clr)               eoi_pending_q <= 1'b0;
            else if (bus.frame_end_i)  eoi_pending_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        eoi_clr = 1'b0;
        advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                // From idle a word is taken only once it has been in the FIFO
                // for a full cycle; a word still in flight also blocks the EOI
                // so that it is emitted ahead of the marker.
                if (!empty) begin
                    if (nonempty_q) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        idx_d   = '0;
                        state_d = S_BYTE;
                    end
                end else if (eoi_pending_q) begin
                    state_d = S_EOI_FF;
                end
            end
            S_BYTE: begin
                if (xfer) begin
                    if (cur_byte == 8'hFF) state_d = S_STUFF;
                    else                   advance = 1'b1;
                end
            end
            S_STUFF: begin
                if (xfer) advance = 1'b1;
            end
            S_EOI_FF: begin
                if (xfer) state_d = S_EOI_D9;
            end
            S_EOI_D9: begin
                if (xfer) begin
                    eoi_clr = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (idx_q == 2'd3) begin
                // Chain straight into the next word to avoid a bubble.
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    idx_d   = '0;
                    state_d = S_BYTE;
                end else begin
                    state_d = S_IDLE;
                end
            end else begin
                shift_d = shift_q << 8;
                idx_d   = idx_q + 1'b1;
                state_d = S_BYTE;
            end
        end
    end

    always_comb begin
        bus.byte_o = 8'h00;
        case (state_q)
            S_BYTE:   bus.byte_o = cur_byte;
            S_STUFF:  bus.byte_o = 8'h00;
            S_EOI_FF: bus.byte_o = 8'hFF;
            S_EOI_D9: bus.byte_o = 8'hD9;
            default:  bus.byte_o = 8'h00;
        endcase
    end

    assign bus.byte_valid_o = (state_q != S_IDLE);
    assign busy_o           = !empty || (state_q != S_IDLE) || eoi_pending_q;
endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
module tb_jpeg_byte_stuffer;
    logic clk_i = 1'b0;
    logic rst_i;
    logic busy_o;
    logic overflow_o;

    jpeg_byte_stuffer_if #(.IN_WIDTH(32)) bus ();

    jpeg_byte_stuffer #(.IN_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (bus.slave),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    logic        busy_after_last;
    logic [31:0] ov_w [6];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic fe);
        bus.enc_word_i  = w;
        bus.enc_valid_i = 1'b1;
        bus.frame_end_i = fe;
        tick();
        bus.enc_valid_i = 1'b0;
        bus.frame_end_i = 1'b0;
    endtask

    // Records every transfer over a fixed number of cycles.
    task automatic collect(input int cycles);
        got.delete();
        busy_after_last = 1'bx;
        repeat (cycles) begin
            logic hit;
            hit = bus.byte_valid_o && bus.byte_ready_i;
            if (hit) got.push_back(bus.byte_o);
            tick();
            if (hit) busy_after_last = busy_o;
        end
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i),
                (i < got.size()) ? 32'(got[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
        end
    endtask

    initial begin
        rst_i            = 1'b1;
        bus.enc_word_i   = '0;
        bus.enc_valid_i  = 1'b0;
        bus.frame_end_i  = 1'b0;
        bus.byte_ready_i = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(bus.byte_valid_o), 0);
        chk("rst_busy",  32'(busy_o), 0);
        chk("rst_ovf",   32'(overflow_o), 0);
        chk("rst_byte",  32'(bus.byte_o), 0);
        rst_i = 1'b0;
        tick();
        chk("idle_valid", 32'(bus.byte_valid_o), 0);

        // Plain word: latency and back-to-back bytes
        send(32'h1234_5678, 1'b0);
        chk("lat_n_valid", 32'(bus.byte_valid_o), 0);
        tick();
        chk("lat_n1_valid", 32'(bus.byte_valid_o), 0);
        tick();
        chk("lat_n2_valid", 32'(bus.byte_valid_o), 1);
        chk("lat_n2_byte",  32'(bus.byte_o), 32'h12);
        collect(4);
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        chk_stream("plain");
        chk("plain_busy_after", 32'(busy_o), 0);

        // Stuffing
        send(32'hFF00_FFAB, 1'b0);
        collect(10);
        exp_q = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hAB};
        chk_stream("stuff");

        // Back-pressure on 0x34
        send(32'h1234_5678, 1'b0);
        tick();
        tick();
        chk("bp_first", 32'(bus.byte_o), 32'h12);
        tick();
        bus.byte_ready_i = 1'b0;
        chk("bp_hold0", 32'(bus.byte_o), 32'h34);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("bp_hold%0d_byte", i),  32'(bus.byte_o), 32'h34);
            chk($sformatf("bp_hold%0d_valid", i), 32'(bus.byte_valid_o), 1);
        end
        bus.byte_ready_i = 1'b1;
        collect(6);
        exp_q = '{8'h34, 8'h56, 8'h78};
        chk_stream("bp");

        // Overflow: 6 words while stalled, word 6 dropped
        ov_w[0] = 32'h0102_0304;
        ov_w[1] = 32'h0506_0708;
        ov_w[2] = 32'h090A_0B0C;
        ov_w[3] = 32'h0D0E_0F10;
        ov_w[4] = 32'h1112_1314;
        ov_w[5] = 32'h1516_1718;
        bus.byte_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) send(ov_w[i], 1'b0);
        chk("ovf_before", 32'(overflow_o), 0);
        send(ov_w[5], 1'b0);
        chk("ovf_set",  32'(overflow_o), 1);
        chk("ovf_busy", 32'(busy_o), 1);
        bus.byte_ready_i = 1'b1;
        collect(30);
        exp_q.delete();
        for (int w = 0; w < 5; w++) begin
            for (int b = 3; b >= 0; b--) exp_q.push_back(ov_w[w][b*8 +: 8]);
        end
        chk_stream("ovf");
        chk("ovf_sticky", 32'(overflow_o), 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("ovf_cleared", 32'(overflow_o), 0);

        // Frame end with the last word
        send(32'hAABB_CCDD, 1'b1);
        collect(14);
        exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hD9};
        chk_stream("eoi");
        chk("eoi_busy_after", 32'(busy_after_last), 0);

        // EOI on empty FIFO; repeated pulse ignored; word waits for EOI
        bus.frame_end_i = 1'b1;
        tick();
        send(32'h1122_3344, 1'b1);
        collect(14);
        exp_q = '{8'hFF, 8'hD9, 8'h11, 8'h22, 8'h33, 8'h44};
        chk_stream("eoi_wait");

        // Reset mid-word; inputs during reset ignored
        send(32'h1234_5678, 1'b0);
        tick();
        tick();
        chk("rstmid_first", 32'(bus.byte_o), 32'h12);
        tick();
        rst_i           = 1'b1;
        bus.enc_word_i  = 32'hDEAD_BEEF;
        bus.enc_valid_i = 1'b1;
        bus.frame_end_i = 1'b1;
        tick();
        rst_i           = 1'b0;
        bus.enc_valid_i = 1'b0;
        bus.frame_end_i = 1'b0;
        chk("rstmid_valid", 32'(bus.byte_valid_o), 0);
        chk("rstmid_busy",  32'(busy_o), 0);
        chk("rstmid_byte",  32'(bus.byte_o), 0);
        send(32'h0102_0304, 1'b0);
        collect(12);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        chk_stream("rstmid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jpeg_byte_stuffer.md
JPEG_BYTE_STUFFER -- requirements
Module: jpeg_byte_stuffer

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 32, giving the encoded word width; only 32 is supported (4 bytes per word).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the input word FIFO depth; it SHALL be a power of 2 and at least 2.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port enc_word_i, input, IN_WIDTH bits: packed entropy-coded word from the encoder, first byte in [31:24].
REQ-006 The block SHALL have port enc_valid_i, input, 1 bit: enc_word_i is valid this cycle; there is no back-pressure to the encoder.
REQ-007 The block SHALL have port frame_end_i, input, 1 bit: one-cycle pulse meaning the last word of the frame has been presented.
REQ-008 The block SHALL have port byte_o, output, 8 bits: stuffed JPEG scan byte.
REQ-009 The block SHALL have port byte_valid_o, output, 1 bit: byte_o is valid.
REQ-010 The block SHALL have port byte_ready_i, input, 1 bit: the sink accepts byte_o; a transfer occurs when byte_valid_o and byte_ready_i are both 1.
REQ-011 The block SHALL have port busy_o, output, 1 bit: high when the FIFO holds a word, a word is being serialized, or an EOI is pending or being sent.
REQ-012 The block SHALL have port overflow_o, output, 1 bit: sticky flag set when an input word is dropped.

Function
REQ-013 When enc_valid_i=1, the block SHALL write enc_word_i into the FIFO at that edge.
REQ-014 When the FIFO is full, a write SHALL be accepted only if a pop happens at the same edge; otherwise the word SHALL be dropped and overflow_o SHALL be set to 1 until reset.
REQ-015 The serializer FSM SHALL have the states IDLE, BYTE, STUFF, EOI_FF and EOI_D9.
REQ-016 In IDLE with the FIFO not empty, the FSM SHALL pop one word into a 32-bit shift register, set the byte index to 0 and go to BYTE.
REQ-017 Latency: a word sampled at edge N into an empty FIFO with the FSM in IDLE SHALL produce its first byte with byte_valid_o=1 after edge N+2.
REQ-018 In BYTE, byte_o SHALL be the current byte, MSB byte first.
REQ-019 On a transfer in BYTE, if the byte equals 0xFF the FSM SHALL go to STUFF; otherwise it SHALL advance to the next byte.
REQ-020 In STUFF, byte_o SHALL be 0x00; on transfer the FSM SHALL advance to the next byte.
REQ-021 When the last byte of a word (or its stuff byte) is transferred, the FSM SHALL, at the same edge, pop and load the next word if the FIFO is not empty (no bubble); otherwise it SHALL go to IDLE.
REQ-022 While byte_valid_o=1 and byte_ready_i=0, byte_o and the FSM state SHALL be held stable, with no byte lost or duplicated.
REQ-023 frame_end_i SHALL set an eoi_pending flag; a pulse arriving while the flag is already set SHALL be ignored.
REQ-024 A word presented in the same cycle as frame_end_i SHALL be emitted before the EOI.
REQ-025 In IDLE with eoi_pending=1 and the FIFO empty, the FSM SHALL go to EOI_FF and emit 0xFF, then go to EOI_D9 and emit 0xD9, both without stuffing.
REQ-026 After the 0xD9 transfer, the block SHALL clear eoi_pending and return to IDLE.
REQ-027 A new word arriving during EOI_FF or EOI_D9 SHALL wait in the FIFO until the EOI completes.
REQ-028 byte_valid_o SHALL be 1 exactly in the states BYTE, STUFF, EOI_FF and EOI_D9.
REQ-029 Sustained throughput SHALL be 1 output byte per cycle while byte_ready_i=1.

Reset
REQ-030 While rst_i=1 at an edge, the FSM SHALL go to IDLE, the FIFO SHALL be emptied, and eoi_pending, overflow_o, byte_valid_o and busy_o SHALL be 0, with byte_o = 0x00.
REQ-031 A reset in mid-word or mid-EOI SHALL discard all buffered data, and the partial output SHALL NOT be resumed.
REQ-032 enc_valid_i and frame_end_i SHALL be ignored while rst_i=1.

Verification
REQ-033 Plain word: 0x12345678 with ready=1 -> bytes 12,34,56,78 on 4 consecutive cycles, the first valid 2 edges after input.
REQ-034 Stuffing: 0xFF00FFAB -> bytes FF,00,00,FF,00,AB (6 transfers).
REQ-035 Back-pressure: ready=0 for 3 cycles while 0x34 is presented -> byte_o holds 0x34; the stream stays 12,34,56,78 with no duplicate.
REQ-036 Overflow: ready=0 and 6 words on consecutive cycles -> words 1-5 retained, word 6 dropped, overflow_o=1; after ready=1, exactly 20 bytes are emitted.
REQ-037 Frame end: 0xAABBCCDD with frame_end_i in the same cycle -> AA,BB,CC,DD,FF,D9, then busy_o=0 one cycle after the D9 transfer.
REQ-038 Reset mid-word: rst_i after the 0x12 transfer -> next cycle byte_valid_o=0 and busy_o=0; a following 0x01020304 -> exactly 01,02,03,04.
